harness_mul_pipe_sat: RTL and testbench

//   Parametrised pipelined multiplier for the harness datapath. Replaces the fixed-width

---
 rtl/harness_mul_pipe_sat.sv | 111 +++++++++++
 tb/tb_harness_mul_pipe_sat.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harness_mul_pipe_sat.sv
// Pipelined multiplier with per-operand signedness, valid/ready handshake with global
// stall, and wrap or saturate fitting of the product into DOUT_WIDTH with an overflow flag.
module harness_mul_pipe_sat #(
   parameter int DIN0_WIDTH  = 8,
   parameter int DIN1_WIDTH  = 7,
   parameter int DIN0_SIGNED = 0,
   parameter int DIN1_SIGNED = 1,
   parameter int DOUT_WIDTH  = 15,
   parameter int NUM_STAGE   = 3,
   parameter int SATURATE    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int P = DIN0_WIDTH + DIN1_WIDTH;
   localparam bit PSIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

   logic            adv;
   logic [P-1:0]    a_ext;
   logic [P-1:0]    b_ext;
   logic [P-1:0]    prod_c;
   logic [P-1:0]    last_prod;
   logic            last_vld;
   logic [DOUT_WIDTH-1:0] fit_dout;
   logic            fit_ovf;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // The true product always fits in P bits, so a P-bit modular multiply of the
   // extended operands yields it exactly.
   assign a_ext  = (DIN0_SIGNED != 0) ? {{(P-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0}
                                      : {{(P-DIN0_WIDTH){1'b0}}, din0};
   assign b_ext  = (DIN1_SIGNED != 0) ? {{(P-DIN1_WIDTH){din1[DIN1_WIDTH-1]}}, din1}
                                      : {{(P-DIN1_WIDTH){1'b0}}, din1};
   assign prod_c = a_ext * b_ext;

   if (NUM_STAGE == 1) begin : g_single
      assign last_prod = prod_c;
      assign last_vld  = in_valid;
   end else begin : g_multi
      logic [P-1:0]           prod_q [NUM_STAGE-1];
      logic [NUM_STAGE-2:0]   vld_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < NUM_STAGE-1; i++) begin
               prod_q[i] <= '0;
            end
            vld_q <= '0;
         end else if (adv) begin
            prod_q[0] <= prod_c;
            vld_q[0]  <= in_valid;
            for (int i = 1; i < NUM_STAGE-1; i++) begin
               prod_q[i] <= prod_q[i-1];
               vld_q[i]  <= vld_q[i-1];
            end
         end
      end

      assign last_prod = prod_q[NUM_STAGE-2];
      assign last_vld  = vld_q[NUM_STAGE-2];
   end

   if (DOUT_WIDTH >= P) begin : g_wide
      if (DOUT_WIDTH == P) begin : g_same
         assign fit_dout = last_prod;
      end else if (PSIGNED) begin : g_sext
         assign fit_dout = {{(DOUT_WIDTH-P){last_prod[P-1]}}, last_prod};
      end else begin : g_zext
         assign fit_dout = {{(DOUT_WIDTH-P){1'b0}}, last_prod};
      end
      assign fit_ovf = 1'b0;
   end else begin : g_narrow
      logic [DOUT_WIDTH-1:0] sat_val;
      if (PSIGNED) begin : g_signed
         // The kept sign bit must agree with every discarded bit above it.
         logic [P-DOUT_WIDTH:0] hi;
         assign hi      = last_prod[P-1:DOUT_WIDTH-1];
         assign fit_ovf = !((&hi) || !(|hi));
         assign sat_val = last_prod[P-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      end else begin : g_unsigned
         assign fit_ovf = |last_prod[P-1:DOUT_WIDTH];
         assign sat_val = '1;
      end
      assign fit_dout = ((SATURATE != 0) && fit_ovf) ? sat_val : last_prod[DOUT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         dout      <= '0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= last_vld;
         dout      <= fit_dout;
         ovf       <= fit_ovf;
      end
   end

endmodule

// File: tb/tb_harness_mul_pipe_sat.sv
// Scoreboard bench: four depth-3 variants share one directed stream; a depth-1 signed
// saturating variant runs a randomised stream against an arithmetic range model.
module tb_harness_mul_pipe_sat;

   typedef struct {
      logic [7:0]  d0;
      logic [6:0]  d1;
      logic [14:0] a;
      logic [14:0] b;
      logic [11:0] c;
      logic        oc;
      logic [11:0] d;
      logic        od;
   } vec_t;

   typedef struct {
      logic [11:0] d;
      logic        o;
      int          cyc;
   } exp_e_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [7:0]  din0;
   logic [6:0]  din1;
   logic        in_ready_a, in_ready_b, in_ready_c, in_ready_d;
   logic        out_valid_a, out_valid_b, out_valid_c, out_valid_d;
   logic [14:0] dout_a, dout_b;
   logic [11:0] dout_c, dout_d;
   logic        ovf_a, ovf_b, ovf_c, ovf_d;

   logic        in_valid_e;
   logic        in_ready_e;
   logic [7:0]  din0_e;
   logic [6:0]  din1_e;
   logic        out_valid_e;
   logic        out_ready_e;
   logic [11:0] dout_e;
   logic        ovf_e;

   int checks = 0;
   int errors = 0;
   int cycle = 0;

   vec_t   vecs[$];
   vec_t   q_abcd[$];
   exp_e_t q_e[$];

   harness_mul_pipe_sat dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
      .din0(din0), .din1(din1), .out_valid(out_valid_a), .out_ready(out_ready),
      .dout(dout_a), .ovf(ovf_a)
   );

   harness_mul_pipe_sat #(.DIN0_SIGNED(1)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
      .din0(din0), .din1(din1), .out_valid(out_valid_b), .out_ready(out_ready),
      .dout(dout_b), .ovf(ovf_b)
   );

   harness_mul_pipe_sat #(.DOUT_WIDTH(12), .SATURATE(1)) dut_c (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
      .din0(din0), .din1(din1), .out_valid(out_valid_c), .out_ready(out_ready),
      .dout(dout_c), .ovf(ovf_c)
   );

   harness_mul_pipe_sat #(.DOUT_WIDTH(12), .SATURATE(0)) dut_d (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d),
      .din0(din0), .din1(din1), .out_valid(out_valid_d), .out_ready(out_ready),
      .dout(dout_d), .ovf(ovf_d)
   );

   harness_mul_pipe_sat #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .DOUT_WIDTH(12),
                          .NUM_STAGE(1), .SATURATE(1)) dut_e (
      .clk(clk), .reset(reset), .in_valid(in_valid_e), .in_ready(in_ready_e),
      .din0(din0_e), .din1(din1_e), .out_valid(out_valid_e), .out_ready(out_ready_e),
      .dout(dout_e), .ovf(ovf_e)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cycle);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: condition not met (cycle %0d)", name, cycle);
   endtask

   task automatic add_vec(input logic [7:0] d0, input logic [6:0] d1, input logic [14:0] a,
                          input logic [14:0] b, input logic [11:0] c, input logic oc,
                          input logic [11:0] d, input logic od);
      vec_t v;
      v.d0 = d0; v.d1 = d1; v.a = a; v.b = b; v.c = c; v.oc = oc; v.d = d; v.od = od;
      vecs.push_back(v);
   endtask

   function automatic exp_e_t model_e(input logic [7:0] a, input logic [6:0] b, input int cyc);
      exp_e_t r;
      int p;
      p = int'($signed(a)) * int'($signed(b));
      r.o = (p > 2047) || (p < -2048);
      if (p > 2047) r.d = 12'h7FF;
      else if (p < -2048) r.d = 12'h800;
      else r.d = p[11:0];
      r.cyc = cyc;
      return r;
   endfunction

   task automatic apply_stimulus(input vec_t v);
      din0     = v.d0;
      din1     = v.d1;
      in_valid = 1'b1;
   endtask

   task automatic drain_abcd(input string name);
      int n = 0;
      while (q_abcd.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q_abcd.size() > 0) fail_now(name);
   endtask

   // Monitor for the shared-stream variants: pops on each output handshake.
   initial begin
      vec_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && out_valid_a) begin
            if (out_ready) begin
               if (q_abcd.size() == 0) begin
                  fail_now("unexpected_out_a");
               end else begin
                  e = q_abcd.pop_front();
                  check_output("dout_a", 16'(dout_a), 16'(e.a));
                  check_output("ovf_a", 16'(ovf_a), 16'h0);
                  check_output("valid_b", 16'(out_valid_b), 16'h1);
                  check_output("dout_b", 16'(dout_b), 16'(e.b));
                  check_output("ovf_b", 16'(ovf_b), 16'h0);
                  check_output("valid_c", 16'(out_valid_c), 16'h1);
                  check_output("dout_c_sat", 16'(dout_c), 16'(e.c));
                  check_output("ovf_c", 16'(ovf_c), 16'(e.oc));
                  check_output("valid_d", 16'(out_valid_d), 16'h1);
                  check_output("dout_d_wrap", 16'(dout_d), 16'(e.d));
                  check_output("ovf_d", 16'(ovf_d), 16'(e.od));
               end
            end else if (q_abcd.size() > 0) begin
               check_output("stall_hold_a", 16'(dout_a), 16'(q_abcd[0].a));
               check_output("stall_hold_c", 16'(dout_c), 16'(q_abcd[0].c));
            end
         end
      end
   end

   // Monitor for the single-stage variant, including exact one-cycle latency.
   initial begin
      exp_e_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && out_valid_e && out_ready_e) begin
            if (q_e.size() == 0) begin
               fail_now("unexpected_out_e");
            end else begin
               e = q_e.pop_front();
               check_output("dout_e", 16'(dout_e), 16'(e.d));
               check_output("ovf_e", 16'(ovf_e), 16'(e.o));
               check_output("latency_e", 16'(cycle - e.cyc), 16'h1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int idx;
      int scyc;
      int budget;
      exp_e_t ee;

      reset       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      din0        = '0;
      din1        = '0;
      in_valid_e  = 1'b0;
      out_ready_e = 1'b1;
      din0_e      = '0;
      din1_e      = '0;

      //       din0   din1   A(u*s,15)  B(s*s,15)  C(sat12) ovf   D(wrap12) ovf
      add_vec(8'hFF, 7'h40, 15'h4040, 15'h0040, 12'h800, 1'b1, 12'h040, 1'b1);
      add_vec(8'h80, 7'h40, 15'h6000, 15'h2000, 12'h800, 1'b1, 12'h000, 1'b1);
      add_vec(8'hFF, 7'h3F, 15'h3EC1, 15'h7FC1, 12'h7FF, 1'b1, 12'hEC1, 1'b1);
      add_vec(8'h00, 7'h7F, 15'h0000, 15'h0000, 12'h000, 1'b0, 12'h000, 1'b0);
      add_vec(8'h10, 7'h7F, 15'h7FF0, 15'h7FF0, 12'hFF0, 1'b0, 12'hFF0, 1'b0);
      add_vec(8'h1F, 7'h42, 15'h787E, 15'h787E, 12'h87E, 1'b0, 12'h87E, 1'b0);
      add_vec(8'h20, 7'h40, 15'h7800, 15'h7800, 12'h800, 1'b0, 12'h800, 1'b0);
      add_vec(8'h41, 7'h1F, 15'h07DF, 15'h07DF, 12'h7DF, 1'b0, 12'h7DF, 1'b0);
      add_vec(8'h20, 7'h20, 15'h0400, 15'h0400, 12'h400, 1'b0, 12'h400, 1'b0);
      add_vec(8'h42, 7'h1F, 15'h07FE, 15'h07FE, 12'h7FE, 1'b0, 12'h7FE, 1'b0);
      add_vec(8'h80, 7'h10, 15'h0800, 15'h7800, 12'h7FF, 1'b1, 12'h800, 1'b1);
      add_vec(8'h7F, 7'h3F, 15'h1F41, 15'h1F41, 12'h7FF, 1'b1, 12'hF41, 1'b1);

      repeat (2) @(negedge clk);
      #1;
      check_output("reset_out_valid", 16'(out_valid_a), 16'h0);
      check_output("reset_dout", 16'(dout_a), 16'h0);
      check_output("reset_ovf", 16'(ovf_a), 16'h0);
      check_output("reset_in_ready", 16'(in_ready_a), 16'h1);
      check_output("reset_dout_c", 16'(dout_c), 16'h0);
      check_output("reset_out_valid_e", 16'(out_valid_e), 16'h0);
      reset = 1'b0;

      $display("[TB] back-to-back stream with stall in cycles 4-6");
      idx = 0;
      scyc = 0;
      while (idx < vecs.size() && scyc < 100) begin
         @(negedge clk);
         out_ready = !(scyc >= 4 && scyc <= 6);
         apply_stimulus(vecs[idx]);
         #1;
         if (scyc >= 4 && scyc <= 6) begin
            check_output("stall_in_ready", 16'(in_ready_a), 16'h0);
         end
         if (in_ready_a) begin
            q_abcd.push_back(vecs[idx]);
            idx++;
         end
         scyc++;
      end
      if (idx < vecs.size()) fail_now("stream_accept_timeout");
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain_abcd("stream_drain");

      $display("[TB] reset with a full stalled pipe");
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         apply_stimulus(vecs[k]);
         #1;
         if (in_ready_a) q_abcd.push_back(vecs[k]);
      end
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      q_abcd.delete();
      @(negedge clk);
      #1;
      check_output("rst_pulse_out_valid", 16'(out_valid_a), 16'h0);
      check_output("rst_pulse_in_ready", 16'(in_ready_a), 16'h1);
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         check_output("no_stale_result", 16'(out_valid_a), 16'h0);
      end
      @(negedge clk);
      apply_stimulus(vecs[2]);
      #1;
      check_output("post_reset_in_ready", 16'(in_ready_a), 16'h1);
      if (in_ready_a) q_abcd.push_back(vecs[2]);
      @(negedge clk);
      in_valid = 1'b0;
      drain_abcd("post_reset_drain");

      $display("[TB] single-stage signed saturating variant, random operands");
      for (int k = 0; k < 10000; k++) begin
         @(negedge clk);
         din0_e     = 8'($urandom);
         din1_e     = 7'($urandom);
         in_valid_e = 1'b1;
         #1;
         check_output("e_in_ready", 16'(in_ready_e), 16'h1);
         if (in_ready_e) begin
            ee = model_e(din0_e, din1_e, cycle);
            q_e.push_back(ee);
         end
      end
      @(negedge clk);
      in_valid_e = 1'b0;
      budget = 0;
      while (q_e.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (q_e.size() > 0) fail_now("e_drain");

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
